// File: rtl/sd_card_pkg.sv
// Shared types and constants for the SD command-line engine.
package sd_card_pkg;

   localparam int unsigned CMD_FRAME_LEN  = 48;
   localparam int unsigned LONG_FRAME_LEN = 136;
   localparam int unsigned RESP_W         = 128;
   localparam int unsigned CRC_W          = 7;
   localparam int unsigned ERR_W          = 4;
   localparam int unsigned IDX_W          = 6;
   localparam int unsigned ARG_W          = 32;

   localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

   localparam int unsigned ERR_TIMEOUT = 0;
   localparam int unsigned ERR_CRC     = 1;
   localparam int unsigned ERR_END     = 2;
   localparam int unsigned ERR_INDEX   = 3;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_TX        = 3'd1;
   localparam logic [2:0] ST_WAIT_RESP = 3'd2;
   localparam logic [2:0] ST_RX        = 3'd3;
   localparam logic [2:0] ST_DONE      = 3'd4;

   typedef enum logic [2:0] {
      IDLE      = ST_IDLE,
      TX        = ST_TX,
      WAIT_RESP = ST_WAIT_RESP,
      RX        = ST_RX,
      DONE      = ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      RESP_NONE        = 2'b00,
      RESP_SHORT       = 2'b01,
      RESP_LONG        = 2'b10,
      RESP_SHORT_NOCRC = 2'b11
   } resp_type_e;

   typedef struct packed {
      logic [IDX_W-1:0] index;
      logic [ARG_W-1:0] arg;
      resp_type_e       rtype;
   } cmd_req_t;

   // One serial step of CRC7 (x^7 + x^3 + 1), MSB-first data.
   function automatic logic [CRC_W-1:0] crc7_next(input logic [CRC_W-1:0] crc,
                                                  input logic din);
      logic fb;
      fb = din ^ crc[CRC_W-1];
      return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator with synchronous clear and bit enable.
module sd_crc7
   import sd_card_pkg::*;
(
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clear_i,
   input  logic             en_i,
   input  logic             bit_i,
   output logic [CRC_W-1:0] crc_o
);

   logic [CRC_W-1:0] crc_q, crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clear_i) begin
         crc_d = '0;
      end else if (en_i) begin
         crc_d = crc7_next(crc_q, bit_i);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: sends a 48-bit command frame and captures/checks the response.
module sd_cmd_engine
   import sd_card_pkg::*;
#(
   parameter int unsigned TIMEOUT_TICKS = 64
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              sd_tick_i,
   input  logic              cmd_start_i,
   input  logic [IDX_W-1:0]  cmd_index_i,
   input  logic [ARG_W-1:0]  cmd_arg_i,
   input  logic [1:0]        resp_type_i,
   output logic              cmd_busy_o,
   output logic              cmd_done_o,
   output logic [ERR_W-1:0]  err_o,
   output logic [RESP_W-1:0] resp_o,
   output logic              sd_cmd_o,
   output logic              sd_cmd_oe_o,
   input  logic              sd_cmd_i
);

   localparam int unsigned CNT_W    = 16;
   localparam int unsigned HDR_BITS = CMD_FRAME_LEN - 8;

   state_e             state_q, state_d;
   cmd_req_t           cmd_q, cmd_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic [RESP_W-1:0]  resp_q, resp_d;
   logic               sd_cmd_q, sd_cmd_d;
   logic               oe_q, oe_d;

   logic               crc_clr_c;
   logic               tx_crc_en_c;
   logic               rx_crc_en_c;
   logic               tx_bit_c;
   logic [CRC_W-1:0]   tx_crc;
   logic [CRC_W-1:0]   rx_crc;
   logic [HDR_BITS-1:0] frame_hdr_c;
   logic [RESP_W-1:0]  resp_shift_c;
   logic [CNT_W-1:0]   rx_last_c;

   assign frame_hdr_c  = {1'b0, 1'b1, cmd_q.index, cmd_q.arg};
   assign resp_shift_c = {resp_q[RESP_W-2:0], sd_cmd_i};
   assign rx_last_c    = (cmd_q.rtype == RESP_LONG) ? CNT_W'(LONG_FRAME_LEN - 2)
                                                    : CNT_W'(CMD_FRAME_LEN - 2);

   // Outgoing bit: header from the latched command, then the running CRC, then end bit.
   always_comb begin
      tx_bit_c = 1'b1;
      if (cnt_q < CNT_W'(HDR_BITS)) begin
         tx_bit_c = frame_hdr_c[6'(CNT_W'(HDR_BITS - 1) - cnt_q)];
      end else if (cnt_q < CNT_W'(CMD_FRAME_LEN - 1)) begin
         tx_bit_c = tx_crc[3'(CNT_W'(CMD_FRAME_LEN - 2) - cnt_q)];
      end
   end

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = err_q;
      resp_d      = resp_q;
      sd_cmd_d    = sd_cmd_q;
      oe_d        = oe_q;
      crc_clr_c   = 1'b0;
      tx_crc_en_c = 1'b0;
      rx_crc_en_c = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_start_i) begin
               cmd_d.index = cmd_index_i;
               cmd_d.arg   = cmd_arg_i;
               cmd_d.rtype = resp_type_e'(resp_type_i);
               cnt_d       = '0;
               busy_d      = 1'b1;
               err_d       = '0;
               crc_clr_c   = 1'b1;
               state_d     = TX;
            end
         end

         // cnt 0..47 put frame bits out; the tick at cnt 48 ends the end-bit period.
         TX: begin
            if (sd_tick_i) begin
               if (cnt_q == CNT_W'(CMD_FRAME_LEN)) begin
                  sd_cmd_d = 1'b1;
                  oe_d     = 1'b0;
                  cnt_d    = '0;
                  if (cmd_q.rtype == RESP_NONE) begin
                     state_d = DONE;
                  end else begin
                     state_d = WAIT_RESP;
                  end
               end else begin
                  sd_cmd_d    = tx_bit_c;
                  oe_d        = 1'b1;
                  cnt_d       = cnt_q + CNT_W'(1);
                  tx_crc_en_c = (cnt_q < CNT_W'(HDR_BITS));
               end
            end
         end

         WAIT_RESP: begin
            if (sd_tick_i) begin
               if (!sd_cmd_i) begin
                  rx_crc_en_c = 1'b1;
                  resp_d      = resp_shift_c;
                  cnt_d       = '0;
                  state_d     = RX;
               end else if (cnt_q == CNT_W'(TIMEOUT_TICKS - 1)) begin
                  err_d[ERR_TIMEOUT] = 1'b1;
                  state_d            = DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         // Start bit already shifted in; resp_q doubles as the receive shift register.
         RX: begin
            if (sd_tick_i) begin
               resp_d      = resp_shift_c;
               rx_crc_en_c = (cmd_q.rtype != RESP_LONG) && (cnt_q < CNT_W'(HDR_BITS - 1));
               if (cnt_q == rx_last_c) begin
                  state_d        = DONE;
                  err_d[ERR_END] = ~sd_cmd_i;
                  if (cmd_q.rtype != RESP_LONG) begin
                     resp_d = RESP_W'(resp_shift_c[45:8]);
                  end
                  if (cmd_q.rtype == RESP_SHORT) begin
                     err_d[ERR_CRC]   = (rx_crc != resp_shift_c[7:1]);
                     err_d[ERR_INDEX] = (resp_shift_c[45:40] != cmd_q.index);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         cmd_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= '0;
         resp_q   <= '0;
         sd_cmd_q <= 1'b1;
         oe_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         resp_q   <= resp_d;
         sd_cmd_q <= sd_cmd_d;
         oe_q     <= oe_d;
      end
   end

   sd_crc7 u_crc_tx (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (crc_clr_c),
      .en_i    (tx_crc_en_c),
      .bit_i   (tx_bit_c),
      .crc_o   (tx_crc)
   );

   sd_crc7 u_crc_rx (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (crc_clr_c),
      .en_i    (rx_crc_en_c),
      .bit_i   (sd_cmd_i),
      .crc_o   (rx_crc)
   );

   assign cmd_busy_o  = busy_q;
   assign cmd_done_o  = done_q;
   assign err_o       = err_q;
   assign resp_o      = resp_q;
   assign sd_cmd_o    = sd_cmd_q;
   assign sd_cmd_oe_o = oe_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine: drives ticks and a card reply model, checks line and results.
module tb_sd_cmd_engine;

   localparam int unsigned TIMEOUT_TICKS = 64;
   localparam logic [127:0] PAT  = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6979;
   localparam logic [127:0] PAT0 = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978;

   logic         clk_i = 1'b0;
   logic         reset_i;
   logic         sd_tick_i;
   logic         cmd_start_i;
   logic [5:0]   cmd_index_i;
   logic [31:0]  cmd_arg_i;
   logic [1:0]   resp_type_i;
   logic         cmd_busy_o;
   logic         cmd_done_o;
   logic [3:0]   err_o;
   logic [127:0] resp_o;
   logic         sd_cmd_o;
   logic         sd_cmd_oe_o;
   logic         sd_cmd_i;

   int checks   = 0;
   int failures = 0;
   int tick_count = 0;

   logic [47:0]  tx_frame;
   int           tx_bits, first_tick, oe_fall_tick, done_tick, start_tick;
   logic         got_done, done_busy, aborted;
   logic [135:0] reply;
   int           reply_len, reply_delay;
   logic         reply_en;

   always #5 clk_i = ~clk_i;

   sd_cmd_engine #(.TIMEOUT_TICKS(TIMEOUT_TICKS)) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .sd_tick_i   (sd_tick_i),
      .cmd_start_i (cmd_start_i),
      .cmd_index_i (cmd_index_i),
      .cmd_arg_i   (cmd_arg_i),
      .resp_type_i (resp_type_i),
      .cmd_busy_o  (cmd_busy_o),
      .cmd_done_o  (cmd_done_o),
      .err_o       (err_o),
      .resp_o      (resp_o),
      .sd_cmd_o    (sd_cmd_o),
      .sd_cmd_oe_o (sd_cmd_oe_o),
      .sd_cmd_i    (sd_cmd_i)
   );

   // Issues one command, records the transmitted frame and timing, plays the reply model.
   task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                          input logic tick_at_start, input int abort_bit, input int ign_bit);
      int   delay_left, bits_left, phase;
      logic prev_oe, resp_phase, last_tick;
      @(negedge clk_i);
      cmd_index_i = idx; cmd_arg_i = arg; resp_type_i = rt;
      cmd_start_i = 1'b1; sd_tick_i = tick_at_start; sd_cmd_i = 1'b1;
      if (tick_at_start) tick_count++;
      start_tick = tick_count;
      tx_frame = '0; tx_bits = 0; first_tick = -1; oe_fall_tick = -1; done_tick = -1;
      got_done = 1'b0; done_busy = 1'b1; aborted = 1'b0;
      delay_left = reply_delay; bits_left = reply_len; phase = 0;
      prev_oe = 1'b0; resp_phase = 1'b0;
      for (int budget = 0; budget < 3000; budget++) begin
         last_tick = sd_tick_i;
         @(negedge clk_i);
         cmd_start_i = 1'b0; sd_tick_i = 1'b0;
         if (budget == 0) begin
            checks++;
            if ({cmd_busy_o, err_o} !== 5'b1_0000) begin
               failures++;
               $display("FAIL start_accept busy_err got=%b exp=%b", {cmd_busy_o, err_o}, 5'b1_0000);
            end
         end
         if (last_tick && sd_cmd_oe_o) begin
            tx_frame = {tx_frame[46:0], sd_cmd_o};
            tx_bits++;
            if (tx_bits == 1) first_tick = tick_count;
         end
         if (prev_oe && !sd_cmd_oe_o) begin
            resp_phase = 1'b1;
            oe_fall_tick = tick_count;
         end
         prev_oe = sd_cmd_oe_o;
         if (cmd_done_o) begin
            got_done = 1'b1; done_tick = tick_count; done_busy = cmd_busy_o;
            break;
         end
         if (abort_bit != 0 && tx_bits == abort_bit) begin
            aborted = 1'b1;
            break;
         end
         if (ign_bit != 0 && tx_bits == ign_bit && last_tick) begin
            cmd_index_i = 6'h3F; cmd_arg_i = 32'hFFFF_FFFF; resp_type_i = 2'b10; cmd_start_i = 1'b1;
         end
         phase++;
         if (phase == 3) begin
            phase = 0; sd_tick_i = 1'b1; tick_count++;
            if (resp_phase && reply_en) begin
               if (delay_left > 0) begin
                  delay_left--; sd_cmd_i = 1'b1;
               end else if (bits_left > 0) begin
                  sd_cmd_i = reply[bits_left-1]; bits_left--;
               end else begin
                  sd_cmd_i = 1'b1;
               end
            end
         end
      end
      cmd_start_i = 1'b0; sd_tick_i = 1'b0; sd_cmd_i = 1'b1;
      if (!got_done && !aborted) begin
         checks++; failures++;
         $display("FAIL cmd_completion got=no_done_in_budget exp=done");
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1; sd_tick_i = 1'b0; cmd_start_i = 1'b0; cmd_index_i = '0;
      cmd_arg_i = '0; resp_type_i = '0; sd_cmd_i = 1'b1; reply_en = 1'b0;
      reply = '0; reply_len = 0; reply_delay = 0;
      repeat (3) @(negedge clk_i);
      checks++;
      if ({sd_cmd_o, sd_cmd_oe_o, cmd_busy_o, cmd_done_o, err_o} !== 8'b1000_0000) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=%b",
                  {sd_cmd_o, sd_cmd_oe_o, cmd_busy_o, cmd_done_o, err_o}, 8'b1000_0000);
      end
      checks++;
      if (resp_o !== 128'd0) begin
         failures++; $display("FAIL reset_resp got=%h exp=0", resp_o);
      end
      reset_i = 1'b0;
      repeat (2) @(negedge clk_i);
   endtask

   task automatic test_cmd0();
      reply_en = 1'b0;
      run_cmd(6'd0, 32'd0, 2'b00, 1'b0, 0, 10);
      checks++;
      if (tx_frame !== 48'h400000000095) begin
         failures++; $display("FAIL cmd0_frame got=%h exp=%h", tx_frame, 48'h400000000095);
      end
      checks++;
      if (tx_bits !== 48) begin
         failures++; $display("FAIL cmd0_bits got=%0d exp=48", tx_bits);
      end
      checks++;
      if (first_tick - start_tick !== 1) begin
         failures++; $display("FAIL cmd0_first_bit_tick got=%0d exp=1", first_tick - start_tick);
      end
      checks++;
      if (done_tick - first_tick !== 48) begin
         failures++; $display("FAIL cmd0_done_latency got=%0d exp=48", done_tick - first_tick);
      end
      checks++;
      if ({done_busy, err_o, sd_cmd_oe_o, sd_cmd_o} !== 7'b0_0000_01) begin
         failures++;
         $display("FAIL cmd0_done_state got=%b exp=%b", {done_busy, err_o, sd_cmd_oe_o, sd_cmd_o}, 7'b0000001);
      end
      @(negedge clk_i);
      checks++;
      if (cmd_done_o !== 1'b0) begin
         failures++; $display("FAIL cmd0_done_pulse_width got=%b exp=0", cmd_done_o);
      end
   endtask

   task automatic test_cmd8_short();
      reply = {88'd0, 48'h08000001AA13}; reply_len = 48; reply_delay = 3; reply_en = 1'b1;
      run_cmd(6'd8, 32'h1AA, 2'b01, 1'b1, 0, 0);
      checks++;
      if (tx_frame !== 48'h48000001AA87) begin
         failures++; $display("FAIL cmd8_frame got=%h exp=%h", tx_frame, 48'h48000001AA87);
      end
      checks++;
      if (first_tick - start_tick !== 1) begin
         failures++; $display("FAIL cmd8_tick_at_start got=%0d exp=1", first_tick - start_tick);
      end
      checks++;
      if (resp_o !== {90'd0, 38'h08000001AA}) begin
         failures++; $display("FAIL cmd8_resp got=%h exp=%h", resp_o, {90'd0, 38'h08000001AA});
      end
      checks++;
      if (err_o !== 4'b0000) begin
         failures++; $display("FAIL cmd8_err got=%b exp=0000", err_o);
      end
   endtask

   task automatic test_timeout();
      reply_en = 1'b0;
      run_cmd(6'd8, 32'h1AA, 2'b01, 1'b0, 0, 0);
      checks++;
      if (err_o !== 4'b0001) begin
         failures++; $display("FAIL timeout_err got=%b exp=0001", err_o);
      end
      checks++;
      if (done_tick - oe_fall_tick !== 64) begin
         failures++; $display("FAIL timeout_ticks got=%0d exp=64", done_tick - oe_fall_tick);
      end
      checks++;
      if (resp_o !== {90'd0, 38'h08000001AA}) begin
         failures++; $display("FAIL timeout_resp_hold got=%h exp=%h", resp_o, {90'd0, 38'h08000001AA});
      end
   endtask

   task automatic test_short_checks();
      reply_delay = 2; reply_len = 48; reply_en = 1'b1;
      reply = {88'd0, 48'h08000001AA25};
      run_cmd(6'd8, 32'h1AA, 2'b01, 1'b0, 0, 0);
      checks++;
      if (err_o !== 4'b0010) begin
         failures++; $display("FAIL crc_bad_err got=%b exp=0010", err_o);
      end
      run_cmd(6'd8, 32'h1AA, 2'b11, 1'b0, 0, 0);
      checks++;
      if (err_o !== 4'b0000) begin
         failures++; $display("FAIL crc_skip_err got=%b exp=0000", err_o);
      end
      checks++;
      if (resp_o !== {90'd0, 38'h08000001AA}) begin
         failures++; $display("FAIL crc_skip_resp got=%h exp=%h", resp_o, {90'd0, 38'h08000001AA});
      end
      reply = {88'd0, 48'h09000001AA13};
      run_cmd(6'd8, 32'h1AA, 2'b01, 1'b0, 0, 0);
      checks++;
      if (err_o !== 4'b1010) begin
         failures++; $display("FAIL index_err got=%b exp=1010", err_o);
      end
      reply = {88'd0, 48'h08000001AA12};
      run_cmd(6'd8, 32'h1AA, 2'b01, 1'b0, 0, 0);
      checks++;
      if (err_o !== 4'b0100) begin
         failures++; $display("FAIL short_end_bit_err got=%b exp=0100", err_o);
      end
   endtask

   task automatic test_long();
      reply = {8'h3F, PAT}; reply_len = 136; reply_delay = 1; reply_en = 1'b1;
      run_cmd(6'd2, 32'd0, 2'b10, 1'b0, 0, 0);
      checks++;
      if (tx_frame !== 48'h42000000004D) begin
         failures++; $display("FAIL cmd2_frame got=%h exp=%h", tx_frame, 48'h42000000004D);
      end
      checks++;
      if (resp_o !== PAT) begin
         failures++; $display("FAIL long_resp got=%h exp=%h", resp_o, PAT);
      end
      checks++;
      if (err_o !== 4'b0000) begin
         failures++; $display("FAIL long_err got=%b exp=0000", err_o);
      end
      reply = {8'h3F, PAT0};
      run_cmd(6'd2, 32'd0, 2'b10, 1'b0, 0, 0);
      checks++;
      if (err_o !== 4'b0100) begin
         failures++; $display("FAIL long_end_bit_err got=%b exp=0100", err_o);
      end
      checks++;
      if (resp_o !== PAT0) begin
         failures++; $display("FAIL long_resp_endbit got=%h exp=%h", resp_o, PAT0);
      end
   endtask

   task automatic test_back_to_back();
      reply_en = 1'b0;
      run_cmd(6'd0, 32'd0, 2'b00, 1'b0, 0, 12);
      checks++;
      if (tx_frame !== 48'h400000000095) begin
         failures++; $display("FAIL b2b_frame got=%h exp=%h", tx_frame, 48'h400000000095);
      end
      checks++;
      if (resp_o !== PAT0 || err_o !== 4'b0000) begin
         failures++; $display("FAIL b2b_hold got=%h/%b exp=%h/0000", resp_o, err_o, PAT0);
      end
   endtask

   task automatic test_reset_abort();
      logic done_seen;
      reply_en = 1'b0;
      run_cmd(6'd8, 32'h1AA, 2'b01, 1'b0, 20, 0);
      reset_i = 1'b1;
      #1;
      checks++;
      if ({sd_cmd_oe_o, sd_cmd_o, cmd_busy_o} !== 3'b010) begin
         failures++;
         $display("FAIL abort_outputs got=%b exp=010", {sd_cmd_oe_o, sd_cmd_o, cmd_busy_o});
      end
      done_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         if (i == 5) reset_i = 1'b0;
         if (cmd_done_o) done_seen = 1'b1;
      end
      checks++;
      if (done_seen !== 1'b0 || cmd_busy_o !== 1'b0) begin
         failures++; $display("FAIL abort_no_done got=%b%b exp=00", done_seen, cmd_busy_o);
      end
      run_cmd(6'd0, 32'd0, 2'b00, 1'b0, 0, 0);
      checks++;
      if (tx_frame !== 48'h400000000095 || got_done !== 1'b1 || err_o !== 4'b0000) begin
         failures++;
         $display("FAIL abort_recover got=%h/%b/%b exp=%h/1/0000", tx_frame, got_done, err_o, 48'h400000000095);
      end
   endtask

   initial begin
      test_reset();
      test_cmd0();
      test_cmd8_short();
      test_timeout();
      test_short_checks();
      test_long();
      test_back_to_back();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
